// File: rtl/sap2_computer_if.sv
// Byte-wide memory bus shared by the SAP-2 CPU (master), boot ROM and RAM.
// Read data from each memory is kept separate; the top-level decoder merges it onto rdata.
interface sap2_computer_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  rom_rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport ram    (input addr, input wdata, input we, output ram_rdata);
    modport rom    (input addr, output rom_rdata);
endinterface

// File: rtl/sap2_computer.sv
// SAP-2-style 8-bit microcomputer: microcoded CPU, 4 KiB boot ROM at 0xF000, 256 B RAM at 0x0000.
// Optional macro SIM_TASKS_EN compiles simulation helper tasks into the memories.
package sap2_pkg;
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_INC   = 3'd4,
        ST_EXEC1 = 3'd5,
        ST_EXEC2 = 3'd6,
        ST_HALT  = 3'd7
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_HLT   = 8'h01;
    localparam logic [7:0] OP_LDI_A = 8'h02;
    localparam logic [7:0] OP_LDI_B = 8'h03;
    localparam logic [7:0] OP_LDI_C = 8'h04;
    localparam logic [7:0] OP_ADD_B = 8'h05;
    localparam logic [7:0] OP_ADD_C = 8'h06;
    localparam logic [7:0] OP_XRA_B = 8'h07;
    localparam logic [7:0] OP_XRA_C = 8'h08;

    localparam logic [1:0] DEST_A = 2'd0;
    localparam logic [1:0] DEST_B = 2'd1;
    localparam logic [1:0] DEST_C = 2'd2;
endpackage

module sap2_control_unit (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       opcode,
    output sap2_pkg::state_t state,
    output logic             operand_phase
);
    import sap2_pkg::*;

    // Microsequencer: byte fetch ADDR/READ/LATCH/INC, then 0-2 execute steps or HALT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_INIT;
            operand_phase <= 1'b0;
        end else begin
            case (state)
                ST_INIT:  state <= ST_ADDR;
                ST_ADDR:  state <= ST_READ;
                ST_READ:  state <= ST_LATCH;
                ST_LATCH: state <= ST_INC;
                ST_INC: begin
                    if (operand_phase) begin
                        operand_phase <= 1'b0;
                        state         <= ST_EXEC1;
                    end else begin
                        case (opcode)
                            OP_HLT: state <= ST_HALT;
                            OP_LDI_A, OP_LDI_B, OP_LDI_C: begin
                                operand_phase <= 1'b1;
                                state         <= ST_ADDR;
                            end
                            OP_ADD_B, OP_ADD_C, OP_XRA_B, OP_XRA_C: state <= ST_EXEC1;
                            default: state <= ST_ADDR;
                        endcase
                    end
                end
                ST_EXEC1: begin
                    if ((opcode == OP_LDI_A) || (opcode == OP_LDI_B) || (opcode == OP_LDI_C)) begin
                        state <= ST_ADDR;
                    end else begin
                        state <= ST_EXEC2;
                    end
                end
                ST_EXEC2: state <= ST_ADDR;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_INIT;
            endcase
        end
    end
endmodule

module sap2_cpu (
    input  logic             clk,
    input  logic             reset,
    sap2_computer_if.master  bus
);
    import sap2_pkg::*;

    state_t      state_s;
    logic        operand_phase_s;
    logic [7:0]  opcode;
    logic [7:0]  temp_1_out;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic [7:0]  c_out;
    logic [15:0] counter_out;
    logic [15:0] mar_r;
    logic        flag_zero_o;
    logic        flag_negative_o;
    logic        flag_carry_o;
    logic [7:0]  operand_r;
    logic [7:0]  wb_value_r;
    logic [1:0]  wb_dest_r;
    logic        wb_pending_r;
    logic        wb_carry_r;
    logic        wb_carry_en_r;
    logic [8:0]  alu_sum_s;
    logic [7:0]  alu_xor_s;
    logic        op_is_ldi_s;
    logic        op_is_add_s;
    logic        op_uses_b_s;
    logic [1:0]  ldi_dest_s;

    sap2_control_unit u_control_unit (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .state         (state_s),
        .operand_phase (operand_phase_s)
    );

    assign bus.addr  = mar_r;
    assign bus.wdata = 8'h00;
    assign bus.we    = 1'b0;

    // Instruction decode and ALU results.
    always_comb begin
        op_is_ldi_s = (opcode == OP_LDI_A) || (opcode == OP_LDI_B) || (opcode == OP_LDI_C);
        op_is_add_s = (opcode == OP_ADD_B) || (opcode == OP_ADD_C);
        op_uses_b_s = (opcode == OP_ADD_B) || (opcode == OP_XRA_B);
        case (opcode)
            OP_LDI_B: ldi_dest_s = DEST_B;
            OP_LDI_C: ldi_dest_s = DEST_C;
            default:  ldi_dest_s = DEST_A;
        endcase
        alu_sum_s = {1'b0, a_out} + {1'b0, operand_r};
        alu_xor_s = a_out ^ operand_r;
    end

    // Datapath; results are staged in wb_* and committed while the next fetch drives ADDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode          <= 8'h00;
            temp_1_out      <= 8'h00;
            a_out           <= 8'h00;
            b_out           <= 8'h00;
            c_out           <= 8'h00;
            counter_out     <= 16'hF000;
            mar_r           <= 16'h0000;
            flag_zero_o     <= 1'b0;
            flag_negative_o <= 1'b0;
            flag_carry_o    <= 1'b0;
            operand_r       <= 8'h00;
            wb_value_r      <= 8'h00;
            wb_dest_r       <= DEST_A;
            wb_pending_r    <= 1'b0;
            wb_carry_r      <= 1'b0;
            wb_carry_en_r   <= 1'b0;
        end else begin
            case (state_s)
                ST_ADDR: begin
                    mar_r <= counter_out;
                    if (wb_pending_r) begin
                        wb_pending_r <= 1'b0;
                        case (wb_dest_r)
                            DEST_A:  a_out <= wb_value_r;
                            DEST_B:  b_out <= wb_value_r;
                            DEST_C:  c_out <= wb_value_r;
                            default: a_out <= a_out;
                        endcase
                        flag_zero_o     <= (wb_value_r == 8'h00);
                        flag_negative_o <= wb_value_r[7];
                        if (wb_carry_en_r) begin
                            flag_carry_o <= wb_carry_r;
                        end
                    end
                end
                ST_LATCH: begin
                    if (operand_phase_s) begin
                        temp_1_out <= bus.rdata;
                    end else begin
                        opcode <= bus.rdata;
                    end
                end
                ST_INC: counter_out <= counter_out + 16'd1;
                ST_EXEC1: begin
                    if (op_is_ldi_s) begin
                        wb_pending_r  <= 1'b1;
                        wb_dest_r     <= ldi_dest_s;
                        wb_value_r    <= temp_1_out;
                        wb_carry_en_r <= 1'b0;
                    end else begin
                        operand_r <= op_uses_b_s ? b_out : c_out;
                    end
                end
                ST_EXEC2: begin
                    wb_pending_r  <= 1'b1;
                    wb_dest_r     <= DEST_A;
                    wb_carry_en_r <= 1'b1;
                    if (op_is_add_s) begin
                        wb_value_r <= alu_sum_s[7:0];
                        wb_carry_r <= alu_sum_s[8];
                    end else begin
                        wb_value_r <= alu_xor_s;
                        wb_carry_r <= 1'b0;
                    end
                end
                default: mar_r <= mar_r;
            endcase
        end
    end
endmodule

module sap2_ram (
    input  logic          clk,
    input  logic          reset,
    sap2_computer_if.ram  bus
);
    logic [7:0] mem [0:255];

    // Byte write when the CPU targets the RAM window.
    always_ff @(posedge clk) begin
        if (bus.we && (bus.addr[15:8] == 8'h00)) begin
            mem[bus.addr[7:0]] <= bus.wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ram_rdata <= 8'h00;
        end else begin
            bus.ram_rdata <= mem[bus.addr[7:0]];
        end
    end

`ifdef SIM_TASKS_EN
    task init_sim_ram();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
        end
    endtask
`else
    // Contents come from device power-up initialisation.
`endif
endmodule

module sap2_rom (
    input  logic          clk,
    input  logic          reset,
    sap2_computer_if.rom  bus
);
    logic [7:0] mem [0:4095];

    // Registered read port; the image is placed in mem by the loader.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rom_rdata <= 8'h00;
        end else begin
            bus.rom_rdata <= mem[bus.addr[11:0]];
        end
    end

`ifdef SIM_TASKS_EN
    task init_sim_rom();
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'h00;
        end
    endtask

    task dump();
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] != 8'h00) begin
                $display("rom %h: %h", 16'hF000 + 16'(i), mem[i]);
            end
        end
    endtask
`else
    // Image comes from the bitstream initialisation of mem.
`endif
endmodule

module sap2_computer (
    input logic clk,
    input logic reset
);
    sap2_computer_if bus ();

    logic ram_sel_r;
    logic rom_sel_r;

    sap2_cpu u_cpu (.clk(clk), .reset(reset), .bus(bus.master));
    sap2_ram u_ram (.clk(clk), .reset(reset), .bus(bus.ram));
    sap2_rom u_rom (.clk(clk), .reset(reset), .bus(bus.rom));

    // Region select registered alongside the memories' one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_sel_r <= 1'b0;
            rom_sel_r <= 1'b0;
        end else begin
            ram_sel_r <= (bus.addr[15:8] == 8'h00);
            rom_sel_r <= (bus.addr[15:12] == 4'hF);
        end
    end

    // Unmapped addresses read as zero.
    always_comb begin
        if (ram_sel_r) begin
            bus.rdata = bus.ram_rdata;
        end else if (rom_sel_r) begin
            bus.rdata = bus.rom_rdata;
        end else begin
            bus.rdata = 8'h00;
        end
    end
endmodule

// File: tb/tb_sap2_computer.sv
// Directed bench for sap2_computer: small ROM programs with hand-computed register/flag values
// sampled 1 time unit after specific clock edges counted from reset release.
module tb_sap2_computer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [7:0] prog_q[$];

    sap2_computer_if mon ();

    sap2_computer dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    assign mon.addr      = dut.bus.addr;
    assign mon.wdata     = dut.bus.wdata;
    assign mon.we        = dut.bus.we;
    assign mon.rdata     = dut.bus.rdata;
    assign mon.ram_rdata = dut.bus.ram_rdata;
    assign mon.rom_rdata = dut.bus.rom_rdata;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_to(input int edge_n);
        while (cyc < edge_n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"},     dut.u_cpu.counter_out, 16'hF000);
        check_eq({tag, "_a"},      {8'h00, dut.u_cpu.a_out}, 16'h0000);
        check_eq({tag, "_c"},      {8'h00, dut.u_cpu.c_out}, 16'h0000);
        check_eq({tag, "_opcode"}, {8'h00, dut.u_cpu.opcode}, 16'h0000);
        check_eq({tag, "_temp1"},  {8'h00, dut.u_cpu.temp_1_out}, 16'h0000);
        check_eq({tag, "_flags"},  {13'h0, dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                                    dut.u_cpu.flag_carry_o}, 16'h0000);
    endtask

    task automatic flags_eq(input string tag, input logic z, input logic n, input logic c);
        check_eq(tag, {13'h0, dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o},
                 {13'h0, z, n, c});
    endtask

    // Holds reset, checks reset values, loads prog_q at 0xF000 and releases reset on a falling edge.
    task automatic restart(input string tag);
        reset = 1'b1;
        #1;
        check_reset_state(tag);
        for (int i = 0; i < 4096; i++) begin
            dut.u_rom.mem[i] = (i < prog_q.size()) ? prog_q[i] : 8'h00;
        end
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1;

        // Program 1: LDI_A FF; LDI_C 05; ADD_C; XRA_C; LDI_C 0F; XRA_C; HLT
        prog_q = '{8'h02, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h08, 8'h04, 8'h0F, 8'h08, 8'h01};
        restart("rst1");
        run_to(2);
        check_eq("bus_addr_opfetch", mon.addr, 16'hF000);
        check_eq("bus_we", {15'h0, mon.we}, 16'h0000);
        run_to(5);
        check_eq("ldia_opcode", {8'h00, dut.u_cpu.opcode}, 16'h0002);
        check_eq("ldia_pc", dut.u_cpu.counter_out, 16'hF001);
        run_to(6);
        check_eq("bus_addr_operand", mon.addr, 16'hF001);
        run_to(9);
        check_eq("ldia_temp1", {8'h00, dut.u_cpu.temp_1_out}, 16'h00FF);
        run_to(11);
        check_eq("ldia_a", {8'h00, dut.u_cpu.a_out}, 16'h00FF);
        flags_eq("ldia_flags", 1'b0, 1'b1, 1'b0);
        run_to(20);
        check_eq("ldic_c", {8'h00, dut.u_cpu.c_out}, 16'h0005);
        flags_eq("ldic_flags", 1'b0, 1'b0, 1'b0);
        run_to(26);
        check_eq("addc_a", {8'h00, dut.u_cpu.a_out}, 16'h0004);
        flags_eq("addc_flags", 1'b0, 1'b0, 1'b1);
        run_to(32);
        check_eq("xrac_a", {8'h00, dut.u_cpu.a_out}, 16'h0001);
        flags_eq("xrac_flags", 1'b0, 1'b0, 1'b0);
        run_to(41);
        check_eq("ldic2_c", {8'h00, dut.u_cpu.c_out}, 16'h000F);
        run_to(47);
        check_eq("xrac2_a", {8'h00, dut.u_cpu.a_out}, 16'h000E);
        flags_eq("xrac2_flags", 1'b0, 1'b0, 1'b0);
        run_to(50);
        check_eq("hlt_opcode", {8'h00, dut.u_cpu.u_control_unit.opcode}, 16'h0001);
        check_eq("hlt_pc", dut.u_cpu.counter_out, 16'hF00A);
        run_to(70);
        check_eq("hlt_pc_hold", dut.u_cpu.counter_out, 16'hF00A);
        check_eq("hlt_a_hold", {8'h00, dut.u_cpu.a_out}, 16'h000E);

        // Program 2: LDI_A 3C; LDI_C 3C; XRA_C; HLT -> zero result
        prog_q = '{8'h02, 8'h3C, 8'h04, 8'h3C, 8'h08, 8'h01};
        restart("rst2");
        run_to(26);
        check_eq("xra_self_a", {8'h00, dut.u_cpu.a_out}, 16'h0000);
        flags_eq("xra_self_flags", 1'b1, 1'b0, 1'b0);
        run_to(29);
        check_eq("xra_self_hlt_pc", dut.u_cpu.counter_out, 16'hF006);

        // Program 3: LDI_A 80; LDI_B 80; ADD_B; HLT -> 0x00 with carry
        prog_q = '{8'h02, 8'h80, 8'h03, 8'h80, 8'h05, 8'h01};
        restart("rst3");
        run_to(11);
        flags_eq("ldia80_flags", 1'b0, 1'b1, 1'b0);
        run_to(26);
        check_eq("addb_a", {8'h00, dut.u_cpu.a_out}, 16'h0000);
        flags_eq("addb_flags", 1'b1, 1'b0, 1'b1);

        // Program 4: NOP; undefined FF; LDI_A 11; HLT
        prog_q = '{8'h00, 8'hFF, 8'h02, 8'h11, 8'h01};
        restart("rst4");
        run_to(9);
        check_eq("undef_opcode", {8'h00, dut.u_cpu.opcode}, 16'h00FF);
        check_eq("undef_pc", dut.u_cpu.counter_out, 16'hF002);
        run_to(19);
        check_eq("nop_ldia_a", {8'h00, dut.u_cpu.a_out}, 16'h0011);
        run_to(22);
        check_eq("nop_hlt_pc", dut.u_cpu.counter_out, 16'hF005);

        // Program 1 again, reset asserted during the LDI_C fetch
        prog_q = '{8'h02, 8'hFF, 8'h04, 8'h05, 8'h06, 8'h08, 8'h04, 8'h0F, 8'h08, 8'h01};
        restart("rst5");
        run_to(13);
        check_eq("mid_opcode_before", {8'h00, dut.u_cpu.opcode}, 16'h0004);
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        run_to(5);
        check_eq("restart_opcode", {8'h00, dut.u_cpu.opcode}, 16'h0002);
        check_eq("restart_pc", dut.u_cpu.counter_out, 16'hF001);
        run_to(11);
        check_eq("restart_a", {8'h00, dut.u_cpu.a_out}, 16'h00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
